plot_arbiter: RTL and testbench

PLOT_ARBITER -- requirements
Module: plot_arbiter

---
 rtl/plot_arbiter_pkg.sv | 35 +++
 rtl/plot_arbiter_if.sv | 45 ++++
 rtl/plot_arbiter_req_slot.sv | 38 +++
 rtl/plot_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_plot_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/plot_arbiter_pkg.sv
// Shared types and constants for the plot arbiter: screen defaults,
// coordinate widths, FSM states, grant classes and the pixel record.
package plot_pkg;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        GRANT_PLAYER = 1'b0,
        GRANT_CPU    = 1'b1
    } grant_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
    } pixel_t;

    localparam pixel_t PIXEL_ZERO = '{x: {X_W{1'b0}}, y: {Y_W{1'b0}}, colour: {COL_W{1'b0}}};

    // Player wins when it is alone, or on a tie when the CPU was served last.
    function automatic logic pick_player(input logic p_full, input logic c_full, input grant_t last);
        return p_full && (!c_full || (last == GRANT_CPU));
    endfunction

endpackage

// File: rtl/plot_arbiter_if.sv
// Request and pixel-output bundle between the requesters and the arbiter.
// master = requester/VGA side, slave = arbiter.
interface plot_arbiter_if;

    logic                        clear_req;
    logic [plot_pkg::COL_W-1:0]  clear_colour;

    logic                        p_req;
    logic [plot_pkg::X_W-1:0]    p_x;
    logic [plot_pkg::Y_W-1:0]    p_y;
    logic [plot_pkg::COL_W-1:0]  p_colour;

    logic                        c_req;
    logic [plot_pkg::X_W-1:0]    c_x;
    logic [plot_pkg::Y_W-1:0]    c_y;
    logic [plot_pkg::COL_W-1:0]  c_colour;

    logic [plot_pkg::X_W-1:0]    x;
    logic [plot_pkg::Y_W-1:0]    y;
    logic [plot_pkg::COL_W-1:0]  colour;
    logic                        plot;

    logic                        p_busy;
    logic                        c_busy;
    logic                        clear_busy;
    logic                        p_done;
    logic                        c_done;

    modport master (
        output clear_req, clear_colour,
        output p_req, p_x, p_y, p_colour,
        output c_req, c_x, c_y, c_colour,
        input  x, y, colour, plot,
        input  p_busy, c_busy, clear_busy, p_done, c_done
    );

    modport slave (
        input  clear_req, clear_colour,
        input  p_req, p_x, p_y, p_colour,
        input  c_req, c_x, c_y, c_colour,
        output x, y, colour, plot,
        output p_busy, c_busy, clear_busy, p_done, c_done
    );

endinterface

// File: rtl/plot_arbiter_req_slot.sv
// One-deep pending slot for a pixel requester. A request is captured when the
// slot is empty, dropped when it is full, and reloads the slot when it lands
// on the same edge the held pixel is granted.
module plot_req_slot
    import plot_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   grant,
    input  pixel_t din,
    output logic   full,
    output pixel_t dout
);

    logic   full_r;
    pixel_t data_r;

    // Slot occupancy and captured pixel data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r <= 1'b0;
            data_r <= PIXEL_ZERO;
        end else if (grant) begin
            full_r <= load;
            if (load) begin
                data_r <= din;
            end
        end else if (load && !full_r) begin
            full_r <= 1'b1;
            data_r <= din;
        end
    end

    assign full = full_r;
    assign dout = data_r;

endmodule

// File: rtl/plot_arbiter.sv
// Arbitrates a full-screen clear sweep and two pixel requesters (player and
// CPU) onto a single registered VGA write port, one pixel per cycle.
module plot_arbiter
    import plot_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic          clk,
    input  logic          resetn,
    plot_arbiter_if.slave bus
);

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);
    localparam logic [X_W-1:0] X_ONE  = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

    state_t             state_r,      state_next_s;
    logic [X_W-1:0]     sx_r,         sx_next_s;
    logic [Y_W-1:0]     sy_r,         sy_next_s;
    logic               clear_pend_r, clear_pend_next_s;
    logic [COL_W-1:0]   clear_col_r,  clear_col_next_s;
    grant_t             last_r,       last_next_s;

    logic [X_W-1:0]     x_r,          x_next_s;
    logic [Y_W-1:0]     y_r,          y_next_s;
    logic [COL_W-1:0]   col_r,        col_next_s;
    logic               plot_r,       plot_next_s;
    logic               p_done_r,     p_done_next_s;
    logic               c_done_r,     c_done_next_s;
    logic               clear_busy_r, clear_busy_next_s;

    pixel_t             p_in_s,   c_in_s;
    pixel_t             p_slot_s, c_slot_s;
    logic               p_full_s, c_full_s;
    logic               p_grant_s, c_grant_s;

    assign p_in_s = '{x: bus.p_x, y: bus.p_y, colour: bus.p_colour};
    assign c_in_s = '{x: bus.c_x, y: bus.c_y, colour: bus.c_colour};

    plot_req_slot u_p_slot (
        .clk   (clk),
        .rst   (resetn),
        .load  (bus.p_req),
        .grant (p_grant_s),
        .din   (p_in_s),
        .full  (p_full_s),
        .dout  (p_slot_s)
    );

    plot_req_slot u_c_slot (
        .clk   (clk),
        .rst   (resetn),
        .load  (bus.c_req),
        .grant (c_grant_s),
        .din   (c_in_s),
        .full  (c_full_s),
        .dout  (c_slot_s)
    );

    // Next-state, sweep counters, grant selection and next output values.
    always_comb begin
        state_next_s      = state_r;
        sx_next_s         = sx_r;
        sy_next_s         = sy_r;
        clear_pend_next_s = clear_pend_r;
        clear_col_next_s  = clear_col_r;
        last_next_s       = last_r;
        x_next_s          = x_r;
        y_next_s          = y_r;
        col_next_s        = col_r;
        plot_next_s       = 1'b0;
        p_done_next_s     = 1'b0;
        c_done_next_s     = 1'b0;
        p_grant_s         = 1'b0;
        c_grant_s         = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (clear_pend_r) begin
                    // Clear outranks pixels; a clear_req on this edge is ignored.
                    state_next_s      = ST_CLEAR;
                    clear_pend_next_s = 1'b0;
                    sx_next_s         = {X_W{1'b0}};
                    sy_next_s         = {Y_W{1'b0}};
                end else begin
                    if (bus.clear_req) begin
                        clear_pend_next_s = 1'b1;
                        clear_col_next_s  = bus.clear_colour;
                    end else begin
                        clear_pend_next_s = 1'b0;
                    end

                    if (pick_player(p_full_s, c_full_s, last_r)) begin
                        p_grant_s     = 1'b1;
                        plot_next_s   = 1'b1;
                        p_done_next_s = 1'b1;
                        x_next_s      = p_slot_s.x;
                        y_next_s      = p_slot_s.y;
                        col_next_s    = p_slot_s.colour;
                        last_next_s   = GRANT_PLAYER;
                    end else if (c_full_s) begin
                        c_grant_s     = 1'b1;
                        plot_next_s   = 1'b1;
                        c_done_next_s = 1'b1;
                        x_next_s      = c_slot_s.x;
                        y_next_s      = c_slot_s.y;
                        col_next_s    = c_slot_s.colour;
                        last_next_s   = GRANT_CPU;
                    end else begin
                        plot_next_s   = 1'b0;
                    end
                end
            end

            ST_CLEAR: begin
                plot_next_s = 1'b1;
                x_next_s    = sx_r;
                y_next_s    = sy_r;
                col_next_s  = clear_col_r;
                if (sx_r == X_LAST) begin
                    sx_next_s = {X_W{1'b0}};
                    if (sy_r == Y_LAST) begin
                        sy_next_s    = {Y_W{1'b0}};
                        state_next_s = ST_IDLE;
                    end else begin
                        sy_next_s    = sy_r + Y_ONE;
                    end
                end else begin
                    sx_next_s = sx_r + X_ONE;
                end
            end

            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        clear_busy_next_s = clear_pend_next_s || (state_next_s == ST_CLEAR);
    end

    // State, sweep, clear latch, round-robin pointer and registered outputs.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_r      <= ST_IDLE;
            sx_r         <= {X_W{1'b0}};
            sy_r         <= {Y_W{1'b0}};
            clear_pend_r <= 1'b0;
            clear_col_r  <= {COL_W{1'b0}};
            last_r       <= GRANT_CPU;
            x_r          <= {X_W{1'b0}};
            y_r          <= {Y_W{1'b0}};
            col_r        <= {COL_W{1'b0}};
            plot_r       <= 1'b0;
            p_done_r     <= 1'b0;
            c_done_r     <= 1'b0;
            clear_busy_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            sx_r         <= sx_next_s;
            sy_r         <= sy_next_s;
            clear_pend_r <= clear_pend_next_s;
            clear_col_r  <= clear_col_next_s;
            last_r       <= last_next_s;
            x_r          <= x_next_s;
            y_r          <= y_next_s;
            col_r        <= col_next_s;
            plot_r       <= plot_next_s;
            p_done_r     <= p_done_next_s;
            c_done_r     <= c_done_next_s;
            clear_busy_r <= clear_busy_next_s;
        end
    end

    assign bus.x          = x_r;
    assign bus.y          = y_r;
    assign bus.colour     = col_r;
    assign bus.plot       = plot_r;
    assign bus.p_done     = p_done_r;
    assign bus.c_done     = c_done_r;
    assign bus.p_busy     = p_full_s;
    assign bus.c_busy     = c_full_s;
    assign bus.clear_busy = clear_busy_r;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: a vector table for pixel arbitration and
// hand-written sequences for the clear sweep and mid-sweep reset.
module tb_plot_arbiter;

    localparam int SW = 160;
    localparam int SH = 120;

    logic clk;
    logic resetn;

    plot_arbiter_if bus ();

    plot_arbiter #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int sweep_bad = -1;

    typedef struct {
        int p_req, px, py, pc;
        int c_req, cx, cy, cc;
        int plot, x, y, col;
        int pd, cd, pb, cb;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input int act, input int exp_v);
        total_cnt++;
        if (act == exp_v) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        bus.p_req     = 1'b0;
        bus.c_req     = 1'b0;
        bus.clear_req = 1'b0;
    endtask

    task automatic drive_p(input int px, input int py, input int pc);
        bus.p_req    = 1'b1;
        bus.p_x      = 8'(px);
        bus.p_y      = 7'(py);
        bus.p_colour = 3'(pc);
    endtask

    task automatic drive_c(input int cx, input int cy, input int cc);
        bus.c_req    = 1'b1;
        bus.c_x      = 8'(cx);
        bus.c_y      = 7'(cy);
        bus.c_colour = 3'(cc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_x"},          int'(bus.x), 0);
        chk({tag, "_y"},          int'(bus.y), 0);
        chk({tag, "_colour"},     int'(bus.colour), 0);
        chk({tag, "_plot"},       int'(bus.plot), 0);
        chk({tag, "_p_done"},     int'(bus.p_done), 0);
        chk({tag, "_c_done"},     int'(bus.c_done), 0);
        chk({tag, "_p_busy"},     int'(bus.p_busy), 0);
        chk({tag, "_c_busy"},     int'(bus.c_busy), 0);
        chk({tag, "_clear_busy"}, int'(bus.clear_busy), 0);
    endtask

    // One sweep cycle: advance, release one-cycle requests, compare pixel n.
    task automatic sweep_pixel(input int n, input int colour);
        tick();
        drop_reqs();
        if ((int'(bus.plot) != 1) || (int'(bus.x) != n % SW) ||
            (int'(bus.y) != n / SW) || (int'(bus.colour) != colour)) begin
            if (sweep_bad < 0) sweep_bad = n;
        end
    endtask

    initial begin
        int plots;

        drop_reqs();
        bus.clear_colour = 3'd0;
        bus.p_x = 8'd0; bus.p_y = 7'd0; bus.p_colour = 3'd0;
        bus.c_x = 8'd0; bus.c_y = 7'd0; bus.c_colour = 3'd0;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        resetn = 1'b0;

        //          p_req px py pc  c_req cx cy cc  plot x  y  col  pd cd pb cb
        vecs[0]  = '{1,  1, 1, 1,   1,  2, 2, 2,   0,  0, 0, 0,   0, 0, 1, 1};
        vecs[1]  = '{0,  0, 0, 0,   0,  0, 0, 0,   1,  1, 1, 1,   1, 0, 0, 1};
        vecs[2]  = '{0,  0, 0, 0,   0,  0, 0, 0,   1,  2, 2, 2,   0, 1, 0, 0};
        vecs[3]  = '{1,  1, 1, 1,   1,  2, 2, 2,   0,  2, 2, 2,   0, 0, 1, 1};
        vecs[4]  = '{0,  0, 0, 0,   0,  0, 0, 0,   1,  1, 1, 1,   1, 0, 0, 1};
        vecs[5]  = '{0,  0, 0, 0,   0,  0, 0, 0,   1,  2, 2, 2,   0, 1, 0, 0};
        vecs[6]  = '{1, 10,20, 3,   0,  0, 0, 0,   0,  2, 2, 2,   0, 0, 1, 0};
        vecs[7]  = '{0,  0, 0, 0,   0,  0, 0, 0,   1, 10,20, 3,   1, 0, 0, 0};
        vecs[8]  = '{0,  0, 0, 0,   0,  0, 0, 0,   0, 10,20, 3,   0, 0, 0, 0};
        vecs[9]  = '{0,  0, 0, 0,   1,  5, 6, 7,   0, 10,20, 3,   0, 0, 0, 1};
        vecs[10] = '{0,  0, 0, 0,   0,  0, 0, 0,   1,  5, 6, 7,   0, 1, 0, 0};
        vecs[11] = '{0,  0, 0, 0,   1,  9, 9, 1,   0,  5, 6, 7,   0, 0, 0, 1};
        vecs[12] = '{0,  0, 0, 0,   0,  0, 0, 0,   1,  9, 9, 1,   0, 1, 0, 0};
        vecs[13] = '{1, 20,30, 2,   0,  0, 0, 0,   0,  9, 9, 1,   0, 0, 1, 0};
        vecs[14] = '{1, 21,31, 4,   0,  0, 0, 0,   1, 20,30, 2,   1, 0, 1, 0};
        vecs[15] = '{0,  0, 0, 0,   0,  0, 0, 0,   1, 21,31, 4,   1, 0, 0, 0};
        vecs[16] = '{1, 40,50, 6,   1, 60,70, 3,   0, 21,31, 4,   0, 0, 1, 1};
        vecs[17] = '{1, 41,51, 1,   0,  0, 0, 0,   1, 60,70, 3,   0, 1, 1, 0};
        vecs[18] = '{0,  0, 0, 0,   0,  0, 0, 0,   1, 40,50, 6,   1, 0, 0, 0};
        vecs[19] = '{0,  0, 0, 0,   0,  0, 0, 0,   0, 40,50, 6,   0, 0, 0, 0};

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].p_req != 0) drive_p(vecs[i].px, vecs[i].py, vecs[i].pc);
            if (vecs[i].c_req != 0) drive_c(vecs[i].cx, vecs[i].cy, vecs[i].cc);
            tick();
            drop_reqs();
            chk($sformatf("v%0d_plot", i),   int'(bus.plot),   vecs[i].plot);
            chk($sformatf("v%0d_x", i),      int'(bus.x),      vecs[i].x);
            chk($sformatf("v%0d_y", i),      int'(bus.y),      vecs[i].y);
            chk($sformatf("v%0d_colour", i), int'(bus.colour), vecs[i].col);
            chk($sformatf("v%0d_p_done", i), int'(bus.p_done), vecs[i].pd);
            chk($sformatf("v%0d_c_done", i), int'(bus.c_done), vecs[i].cd);
            chk($sformatf("v%0d_p_busy", i), int'(bus.p_busy), vecs[i].pb);
            chk($sformatf("v%0d_c_busy", i), int'(bus.c_busy), vecs[i].cb);
        end

        // Full clear sweep with a CPU pixel captured mid-sweep.
        bus.clear_req    = 1'b1;
        bus.clear_colour = 3'd5;
        tick();
        drop_reqs();
        chk("clr_busy_pending", int'(bus.clear_busy), 1);
        chk("clr_plot_pending", int'(bus.plot), 0);
        tick();
        chk("clr_busy_enter", int'(bus.clear_busy), 1);
        chk("clr_plot_enter", int'(bus.plot), 0);
        sweep_bad = -1;
        for (int n = 0; n < SW * SH; n++) begin
            sweep_pixel(n, 5);
            if (n == 100) drive_c(7, 7, 6);
            if (n == 101) chk("clr_c_busy_captured", int'(bus.c_busy), 1);
            if (n == 200) drive_c(8, 8, 1);
            if (n == 300) begin
                bus.clear_req    = 1'b1;
                bus.clear_colour = 3'd2;
            end
            if (n == SW * SH - 2) chk("clr_busy_before_last", int'(bus.clear_busy), 1);
            if (n == SW * SH - 1) begin
                chk("clr_busy_after_last", int'(bus.clear_busy), 0);
                chk("clr_c_still_pending", int'(bus.c_busy), 1);
            end
        end
        chk("clr_first_bad_pixel", sweep_bad, -1);
        tick();
        chk("post_clr_plot",   int'(bus.plot), 1);
        chk("post_clr_x",      int'(bus.x), 7);
        chk("post_clr_y",      int'(bus.y), 7);
        chk("post_clr_colour", int'(bus.colour), 6);
        chk("post_clr_c_done", int'(bus.c_done), 1);
        tick();
        chk("post_clr_idle_plot", int'(bus.plot), 0);
        chk("post_clr_c_busy",    int'(bus.c_busy), 0);
        chk("post_clr_clr_busy",  int'(bus.clear_busy), 0);
        plots = 0;
        repeat (5) begin
            tick();
            if (bus.plot === 1'b1) plots++;
        end
        chk("post_clr_no_extra_plots", plots, 0);

        // Reset mid-sweep with a player pixel pending.
        bus.clear_req    = 1'b1;
        bus.clear_colour = 3'd2;
        tick();
        drop_reqs();
        tick();
        sweep_bad = -1;
        for (int n = 0; n <= 5000; n++) begin
            sweep_pixel(n, 2);
            if (n == 10) drive_p(30, 30, 1);
            if (n == 11) chk("rst_p_pending", int'(bus.p_busy), 1);
        end
        chk("rst_sweep_first_bad", sweep_bad, -1);
        #1;
        resetn = 1'b1;
        #1;
        check_zero("rst_mid");
        tick();
        resetn = 1'b0;
        plots = 0;
        repeat (30) begin
            tick();
            if (bus.plot === 1'b1) plots++;
        end
        chk("rst_no_plots_after", plots, 0);
        check_zero("rst_after");

        // Request on the very first edge after a reset release.
        resetn = 1'b1;
        #2;
        resetn = 1'b0;
        drive_p(3, 3, 3);
        tick();
        drop_reqs();
        chk("rel_p_busy", int'(bus.p_busy), 1);
        chk("rel_plot0",  int'(bus.plot), 0);
        tick();
        chk("rel_plot",   int'(bus.plot), 1);
        chk("rel_x",      int'(bus.x), 3);
        chk("rel_colour", int'(bus.colour), 3);
        chk("rel_p_done", int'(bus.p_done), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
